// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and constants for the I2C register-file target
// Contents: FSM state type, transfer direction type, ACK bus level.

package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  // Value of the R/W bit that follows the 7-bit target address.
  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } i2c_op_t;

  // Bus level that acknowledges a byte.
  localparam logic I2C_ACK = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - scl/sda synchronizer with edge, START and STOP detection
// Ports:
//   clk_i, rst_i           system clock, synchronous active-high reset
//   scl_i, sda_i           asynchronous bus pins
//   sda_level              synchronized sda, aligned with the registered events
//   scl_rise, scl_fall     one-cycle scl edge events
//   start_det, stop_det    one-cycle START / STOP events
// Every event appears SYNC_STAGES+1 clk_i cycles after the pin edge.

module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;
  logic                   sda_now;
  logic                   sda_rise;
  logic                   sda_fall;

  assign scl_now  = scl_sync[SYNC_STAGES-1];
  assign sda_now  = sda_sync[SYNC_STAGES-1];
  assign sda_rise = sda_now & ~sda_hist;
  assign sda_fall = ~sda_now & sda_hist;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Idle bus is high on both wires, so no edge is seen leaving reset
      // while the bus is idle.
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_hist  <= 1'b1;
      sda_hist  <= 1'b1;
      sda_level <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_hist  <= scl_now;
      sda_hist  <= sda_now;
      sda_level <= sda_now;
      scl_rise  <= scl_now & ~scl_hist;
      scl_fall  <= ~scl_now & scl_hist;
      // scl must be high both before and after the sda edge; an sda edge
      // that lands together with scl_rise is therefore plain data.
      start_det <= scl_hist & scl_now & sda_fall;
      stop_det  <= scl_hist & scl_now & sda_rise;
    end
  end

endmodule

// File: rtl/i2c_target_mem.sv
// rtl/i2c_target_mem.sv - I2C target with an auto-incrementing byte register file
// Ports:
//   clk_i, rst_i     system clock, synchronous active-high reset
//   scl_i, sda_i     asynchronous bus pins (oversampled)
//   sda_o            open-drain drive: 0 pulls low, 1 releases
//   busy_o           addressed transfer in progress (START..STOP)
//   start_o, stop_o  one-cycle pulses on START / repeated START and STOP
//   wr_strobe_o      one-cycle pulse per stored data byte
//   wr_addr_o        register-file index of the stored byte
//   wr_data_o        stored byte

module i2c_target_mem
  import i2c_target_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22,
  parameter int                        DEPTH          = 64,
  parameter int                        SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      busy_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      wr_strobe_o,
  output logic [$clog2(DEPTH)-1:0]  wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o
);

  localparam int DW = I2C_DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DW + 3);

  // Bit counter milestones: last data bit sampled, ACK slot driven,
  // ACK slot ended, and (reads only) controller ACK sampled.
  localparam logic [CW-1:0] CNT_LAST    = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ACK     = CW'(DW);
  localparam logic [CW-1:0] CNT_ACK_END = CW'(DW + 1);
  localparam logic [CW-1:0] CNT_NEXT    = CW'(DW + 2);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_level (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state;
  i2c_tgt_state_t state_d;
  logic [CW-1:0]  bit_cnt;
  logic [CW-1:0]  cnt_d;
  logic [DW-1:0]  shreg;
  logic [DW-1:0]  sh_d;
  logic [DW-1:0]  rx_byte;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  ptr_d;
  i2c_op_t        op;
  i2c_op_t        op_d;
  logic           sda_d;
  logic           busy_d;
  logic           wr_en;
  logic [DW-1:0]  mem [DEPTH];

  // Byte as it stands once the current sda sample is shifted in.
  assign rx_byte = {shreg[DW-2:0], sda_s};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = bit_cnt;
    sh_d    = shreg;
    ptr_d   = ptr;
    op_d    = op;
    sda_d   = sda_o;
    busy_d  = busy_o;
    wr_en   = 1'b0;

    if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = bit_cnt + CW'(1);
            if (bit_cnt == CNT_LAST) begin
              // shreg already holds the 7 address bits; sda_s is R/W.
              if (shreg[I2C_ADDR_WIDTH-1:0] == TARGET_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                op_d    = i2c_op_t'(sda_s);
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == CNT_ACK) begin
              sda_d = I2C_ACK;
              cnt_d = CNT_ACK_END;
            end else if (bit_cnt == CNT_ACK_END) begin
              cnt_d = '0;
              sda_d = 1'b1;
              if (state == ADDR_ACK && op == READ) begin
                // First read bit goes out on the same edge that ends the ACK.
                state_d = RD;
                sh_d    = mem[ptr];
                sda_d   = mem[ptr][DW-1];
              end else if (state == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WR;
                if (state == WR_ACK) begin
                  ptr_d = ptr + PW'(1);
                end
              end
            end
          end
        end

        PTR, WR: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = bit_cnt + CW'(1);
            if (bit_cnt == CNT_LAST) begin
              if (state == PTR) begin
                ptr_d   = rx_byte[PW-1:0];
                state_d = PTR_ACK;
              end else begin
                wr_en   = 1'b1;
                state_d = WR_ACK;
              end
            end
          end
        end

        RD: begin
          if (scl_rise) begin
            cnt_d = bit_cnt + CW'(1);
            if (bit_cnt == CNT_LAST) begin
              state_d = RD_ACK;
            end
          end else if (scl_fall && bit_cnt != '0) begin
            sda_d = shreg[DW-2];
            sh_d  = {shreg[DW-2:0], 1'b0};
          end
        end

        RD_ACK: begin
          if (scl_fall && bit_cnt == CNT_ACK) begin
            sda_d = 1'b1;
            cnt_d = CNT_ACK_END;
          end else if (scl_rise && bit_cnt == CNT_ACK_END) begin
            ptr_d = ptr + PW'(1);
            if (sda_s != I2C_ACK) begin
              state_d = WAIT_STOP;
            end else begin
              cnt_d = CNT_NEXT;
            end
          end else if (scl_fall && bit_cnt == CNT_NEXT) begin
            state_d = RD;
            cnt_d   = '0;
            sh_d    = mem[ptr];
            sda_d   = mem[ptr][DW-1];
          end
        end

        default: begin
          // IDLE and WAIT_STOP only leave on START/STOP.
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      op          <= WRITE;
      sda_o       <= 1'b1;
      busy_o      <= 1'b0;
      start_o     <= 1'b0;
      stop_o      <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DW'((i + 100) % 256);
      end
    end else begin
      bit_cnt     <= cnt_d;
      shreg       <= sh_d;
      ptr         <= ptr_d;
      op          <= op_d;
      sda_o       <= sda_d;
      busy_o      <= busy_d;
      start_o     <= start_det;
      stop_o      <= stop_det;
      wr_strobe_o <= wr_en;
      if (wr_en) begin
        mem[ptr]  <= rx_byte;
        wr_addr_o <= ptr;
        wr_data_o <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// tb/tb_i2c_target_mem.sv - directed bench for i2c_target_mem with a bit-banged controller

module tb_i2c_target_mem;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_o;
  logic       busy_o;
  logic       start_o;
  logic       stop_o;
  logic       wr_strobe_o;
  logic [5:0] wr_addr_o;
  logic [7:0] wr_data_o;

  int tests_run = 0;
  int tests_failed = 0;

  int start_cnt = 0;
  int stop_cnt = 0;
  int busy_cnt = 0;
  int wa_q[$];
  int wd_q[$];

  assign sda_bus = sda_m & sda_o;

  i2c_target_mem dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .busy_o      (busy_o),
    .start_o     (start_o),
    .stop_o      (stop_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (wr_strobe_o) begin
        wa_q.push_back(int'(wr_addr_o));
        wd_q.push_back(int'(wr_data_o));
      end
      if (start_o) start_cnt++;
      if (stop_o) stop_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(6);
    end
    sda_m = 1'b0;
    wait_clk(8);
    scl = 1'b0;
    wait_clk(6);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(8);
    sda_m = 1'b1;
    wait_clk(10);
  endtask

  // Entered 6 cycles into scl low; returns 6 cycles into the next scl low.
  task automatic send_bit(input logic b, output logic rx);
    sda_m = b;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(6);
    rx = sda_bus;
    wait_clk(6);
    scl = 1'b0;
    wait_clk(6);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i], b);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, b);
      d[i] = b;
    end
    send_bit(ack, b);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         sb;
    int         st;
    int         sp;
    int         bc;

    // Reset values
    wait_clk(3);
    expect_eq("rst_sda", sda_o, 1'b1);
    expect_eq("rst_busy", busy_o, 1'b0);
    expect_eq("rst_start", start_o, 1'b0);
    expect_eq("rst_stop", stop_o, 1'b0);
    expect_eq("rst_strobe", wr_strobe_o, 1'b0);
    expect_eq("rst_waddr", wr_addr_o, 6'd0);
    expect_eq("rst_wdata", wr_data_o, 8'd0);
    rst_i = 1'b0;
    wait_clk(10);

    // Write pointer 5, data A1 A2
    sb = wa_q.size();
    sp = stop_cnt;
    i2c_start();
    write_byte(8'h44, ack); expect_eq("w1_addr_ack", ack, 1'b0);
    expect_eq("w1_busy", busy_o, 1'b1);
    write_byte(8'h05, ack); expect_eq("w1_ptr_ack", ack, 1'b0);
    write_byte(8'hA1, ack); expect_eq("w1_d0_ack", ack, 1'b0);
    write_byte(8'hA2, ack); expect_eq("w1_d1_ack", ack, 1'b0);
    i2c_stop();
    expect_eq("w1_stop_pulse", stop_cnt - sp, 1);
    expect_eq("w1_busy_after", busy_o, 1'b0);
    expect_eq("w1_nstrobe", wa_q.size() - sb, 2);
    if (wa_q.size() >= sb + 2) begin
      expect_eq("w1_a0", wa_q[sb], 5);
      expect_eq("w1_d0", wd_q[sb], 8'hA1);
      expect_eq("w1_a1", wa_q[sb+1], 6);
      expect_eq("w1_d1", wd_q[sb+1], 8'hA2);
    end

    // Pointer 0, repeated START, read 3 bytes
    st = start_cnt;
    i2c_start();
    write_byte(8'h44, ack); expect_eq("r1_addr_ack", ack, 1'b0);
    write_byte(8'h00, ack); expect_eq("r1_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'h45, ack); expect_eq("r1_raddr_ack", ack, 1'b0);
    read_byte(1'b0, d); expect_eq("r1_b0", d, 8'd100);
    read_byte(1'b0, d); expect_eq("r1_b1", d, 8'd101);
    read_byte(1'b1, d); expect_eq("r1_b2", d, 8'd102);
    expect_eq("r1_release", sda_o, 1'b1);
    i2c_stop();
    expect_eq("r1_starts", start_cnt - st, 2);

    // Wrong address 0x23
    sb = wa_q.size();
    bc = busy_cnt;
    i2c_start();
    write_byte(8'h46, ack); expect_eq("na_ack", ack, 1'b1);
    write_byte(8'h55, ack); expect_eq("na_data_ack", ack, 1'b1);
    i2c_stop();
    expect_eq("na_busy", busy_cnt - bc, 0);
    expect_eq("na_nstrobe", wa_q.size() - sb, 0);

    // Pointer wrap 63 -> 0
    sb = wa_q.size();
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h3F, ack);
    write_byte(8'h11, ack); expect_eq("wrap_d0_ack", ack, 1'b0);
    write_byte(8'h22, ack); expect_eq("wrap_d1_ack", ack, 1'b0);
    i2c_stop();
    expect_eq("wrap_nstrobe", wa_q.size() - sb, 2);
    if (wa_q.size() >= sb + 2) begin
      expect_eq("wrap_a0", wa_q[sb], 63);
      expect_eq("wrap_a1", wa_q[sb+1], 0);
    end
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h3F, ack);
    i2c_start();
    write_byte(8'h45, ack);
    read_byte(1'b0, d); expect_eq("wrap_rd0", d, 8'h11);
    read_byte(1'b1, d); expect_eq("wrap_rd1", d, 8'h22);
    i2c_stop();

    // Reset during 4th read bit of mem[1]=0x65 (bit 4 is 0)
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(8'h45, ack);
    for (int i = 0; i < 3; i++) send_bit(1'b1, b);
    expect_eq("mrst_drive_low", sda_o, 1'b0);
    rst_i = 1'b1;
    wait_clk(1);
    expect_eq("mrst_release", sda_o, 1'b1);
    expect_eq("mrst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    scl = 1'b1;
    sda_m = 1'b1;
    wait_clk(12);
    i2c_start();
    write_byte(8'h45, ack); expect_eq("mrst_addr_ack", ack, 1'b0);
    read_byte(1'b1, d); expect_eq("mrst_rd0", d, 8'd100);
    i2c_stop();

    // Repeated START in the middle of a data byte
    sb = wa_q.size();
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h10, ack);
    st = start_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'b0, b);
    i2c_start();
    expect_eq("rs_start_pulse", start_cnt - st, 1);
    write_byte(8'h44, ack); expect_eq("rs_addr_ack", ack, 1'b0);
    i2c_stop();
    expect_eq("rs_nstrobe", wa_q.size() - sb, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
